// File: rtl/rca_word_sequencer.sv
// Wide adder controller: feeds one SIZE-bit slice per cycle through an external
// ripple-carry adder, chains the carry in a register and assembles the wide sum.
module rca_word_sequencer #(
  parameter  int SIZE  = 16,
  parameter  int WORDS = 4,
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start_Valid,
  output logic                  Start_Ready,
  input  logic [SIZE*WORDS-1:0] Op_A,
  input  logic [SIZE*WORDS-1:0] Op_B,
  input  logic                  Cin_In,
  output logic [SIZE-1:0]       Rca_A,
  output logic [SIZE-1:0]       Rca_B,
  output logic                  Rca_Cin,
  input  logic [SIZE-1:0]       Rca_Sum,
  input  logic                  Rca_Cout,
  output logic [SIZE*WORDS-1:0] Result,
  output logic                  Cout_Out,
  output logic                  Done_Valid,
  input  logic                  Done_Ready,
  output logic                  Busy,
  output logic [IDX_W-1:0]      Word_Idx
);

  localparam int               SLOTS    = 2 ** IDX_W;
  localparam int               PAD_W    = SIZE * SLOTS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [SIZE*WORDS-1:0]   a_reg, b_reg;
  logic                    carry_reg;
  logic                    cout_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic                    accept;
  logic [PAD_W-1:0]        a_pad, b_pad;

  // Padding to a power-of-two slot count keeps the indexed slice always in range.
  assign a_pad = PAD_W'(a_reg);
  assign b_pad = PAD_W'(b_reg);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    Start_Ready = 1'b0;
    Busy        = 1'b0;
    Done_Valid  = 1'b0;
    Rca_A       = '0;
    Rca_B       = '0;
    Rca_Cin     = 1'b0;
    accept      = 1'b0;
    case (state_reg)
      IDLE: begin
        Start_Ready = 1'b1;
        if (Start_Valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        Busy    = 1'b1;
        Rca_A   = a_pad[idx_reg*SIZE +: SIZE];
        Rca_B   = b_pad[idx_reg*SIZE +: SIZE];
        Rca_Cin = carry_reg;
        if (idx_reg == LAST_IDX) begin
          state_next = DONE;
        end
      end
      DONE: begin
        Busy       = 1'b1;
        Done_Valid = 1'b1;
        if (Done_Ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      idx_reg   <= '0;
    end else if (accept) begin
      a_reg     <= Op_A;
      b_reg     <= Op_B;
      carry_reg <= Cin_In;
      cout_reg  <= 1'b0;
      idx_reg   <= '0;
    end else if (state_reg == RUN) begin
      carry_reg <= Rca_Cout;
      if (idx_reg == LAST_IDX) begin
        cout_reg <= Rca_Cout;
      end else begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  // Each result slice owns its own register so only the active slice is written.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_res
      logic [SIZE-1:0] slice_reg;
      always_ff @(posedge Clk) begin
        if (!Rst_n || accept) begin
          slice_reg <= '0;
        end else if (state_reg == RUN && idx_reg == IDX_W'(gi)) begin
          slice_reg <= Rca_Sum;
        end
      end
      assign Result[gi*SIZE +: SIZE] = slice_reg;
    end
  endgenerate

  assign Cout_Out = cout_reg;
  assign Word_Idx = idx_reg;

endmodule

// File: doc/rca_word_sequencer.md
Name: rca_word_sequencer

Overview:
- Multi-cycle wide adder controller: adds two WORDS*SIZE-bit operands by stepping one SIZE-bit slice per cycle through a single shared FAnbit_RCA instance (ports Port_A, Port_B, Cin, Port_Sum, Cout).
- Chains the carry between slices in a register and assembles the wide result.
- Valid/ready handshake on both the request side and the result side.
- The RCA sits outside this block; this block drives its inputs and samples its outputs in the same cycle.

Parameters:
- SIZE, 16, slice width in bits; equals the SIZE of the attached FAnbit_RCA; must be >= 1.
- WORDS, 4, number of slices per operation; must be >= 1.
- IDX_W (localparam), (WORDS>1 ? $clog2(WORDS) : 1), width of the slice index.

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Rst_n  input  1  reset, synchronous, active-low.
- Start_Valid  input  1  request valid.
- Start_Ready  output  1  block can accept a request.
- Op_A  input  SIZE*WORDS  operand A; slice w is bits [w*SIZE +: SIZE].
- Op_B  input  SIZE*WORDS  operand B.
- Cin_In  input  1  carry-in to slice 0.
- Rca_A  output  SIZE  to RCA Port_A.
- Rca_B  output  SIZE  to RCA Port_B.
- Rca_Cin  output  1  to RCA Cin.
- Rca_Sum  input  SIZE  from RCA Port_Sum; combinational function of Rca_A, Rca_B, Rca_Cin.
- Rca_Cout  input  1  from RCA Cout.
- Result  output  SIZE*WORDS  wide sum.
- Cout_Out  output  1  final carry-out.
- Done_Valid  output  1  Result and Cout_Out are valid.
- Done_Ready  input  1  consumer accepts the result.
- Busy  output  1  high in RUN or DONE.
- Word_Idx  output  IDX_W  slice currently presented to the RCA.

Behaviour:
- Reset: when Rst_n is low at a rising edge, the following take effect after that edge.
  - State goes to IDLE.
  - Operand registers, carry register, Result, Cout_Out and Word_Idx are cleared to 0.
  - Reset takes priority over every other event, including mid-RUN and in DONE; the operation in progress is discarded with no Done_Valid.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Start_Ready=1; Busy=0; Done_Valid=0.
  - Rca_A, Rca_B and Rca_Cin are driven to 0.
  - On Start_Valid&&Start_Ready: capture Op_A, Op_B and Cin_In into internal registers (carry register <= Cin_In), set Word_Idx<=0, Result<=0, Cout_Out<=0, then go to RUN.
- RUN:
  - Start_Ready=0; Busy=1.
  - Rca_A = a_reg slice Word_Idx; Rca_B = b_reg slice Word_Idx; Rca_Cin = carry register. These are registered-state driven, with no combinational path from the top-level inputs.
  - Each edge: Result slice Word_Idx <= Rca_Sum; carry register <= Rca_Cout.
  - If Word_Idx==WORDS-1: Cout_Out <= Rca_Cout and go to DONE. Otherwise Word_Idx <= Word_Idx+1.
- DONE:
  - Done_Valid=1; Busy=1; Start_Ready=0.
  - Result and Cout_Out are held stable; RCA inputs are driven to 0.
  - On Done_Ready=1: go to IDLE. Result and Cout_Out keep their values until the next accept.
- Latency:
  - Done_Valid rises exactly WORDS cycles after the accept edge.
  - Minimum request-to-request spacing is WORDS+2 cycles, since back-to-back accept in DONE is not allowed.
- Boundaries:
  - Start_Valid outside IDLE is ignored and has no side effects; Op_A and Op_B changes during RUN do not affect the result.
  - Done_Ready outside DONE is ignored.
  - WORDS=1: RUN lasts one cycle and Word_Idx stays 0.
  - Arithmetic is modulo 2^(SIZE*WORDS) with the carry reported on Cout_Out; equivalent to {Cout_Out,Result} = Op_A + Op_B + Cin_In.

Test Plan:
- Reset: hold Rst_n low 2 cycles mid-stream, then release -> Start_Ready=1, Busy=0, Done_Valid=0, Result=0, Cout_Out=0, Rca_A/Rca_B/Rca_Cin=0.
- Cross-word carry (SIZE=16, WORDS=4): A=0x0000_FFFF_FFFF_FFFF, B=0x1, Cin=0 -> Word_Idx 0,1,2,3 on consecutive cycles; Rca_Cin=0,1,1,1; Done_Valid exactly 4 cycles after accept; Result=0x0001_0000_0000_0000, Cout_Out=0.
- Full overflow: A=0xFFFF_FFFF_FFFF_FFFF, B=0, Cin=1 -> Result=0, Cout_Out=1. Also A=B=all-ones, Cin=1 -> Result=all-ones, Cout_Out=1.
- Backpressure: Done_Ready low 5 cycles while Start_Valid pulses and Op_A changes -> Done_Valid stays 1, Result stable, Start_Ready=0, no new op accepted; Done_Ready=1 -> IDLE next cycle.
- Reset mid-RUN at Word_Idx=2 -> IDLE after edge, no Done_Valid; next request A=0x1234, B=0x4321 -> Result=0x5555, Cout_Out=0.
- Randomised: 1000 ops against an integer reference model with the team FAnbit_RCA attached. Run at SIZE=16/WORDS=4, SIZE=8/WORDS=1 and SIZE=4/WORDS=3, with random Done_Ready stalls -> zero mismatches.
